// File: rtl/pipe_reg_mw.sv
// MEM->WB pipeline register with valid bits, load extraction, result mux and retire counter.
// Latency DEPTH edges; StallW holds every stage, FlushW clears every valid bit and wins over stall.
module pipe_reg_mw #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FUNCT3_WIDTH  = 3,
    parameter int DEPTH         = 1,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     StallW,
    input  logic                     FlushW,
    input  logic                     ValidM,
    input  logic                     RegWriteM,
    input  logic [1:0]               ResultSrcM,
    input  logic [DATA_WIDTH-1:0]    ALUResultM,
    input  logic [DATA_WIDTH-1:0]    RD,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [DATA_WIDTH-1:0]    PCPlus4M,
    input  logic [FUNCT3_WIDTH-1:0]  funct3M,
    output logic                     ValidW,
    output logic                     RegWriteW,
    output logic [1:0]               ResultSrcW,
    output logic [DATA_WIDTH-1:0]    ALUResultW,
    output logic [ADDRESS_WIDTH-1:0] RdW,
    output logic [DATA_WIDTH-1:0]    PCPlus4W,
    output logic [FUNCT3_WIDTH-1:0]  funct3W,
    output logic [DATA_WIDTH-1:0]    ReadDataW,
    output logic [DATA_WIDTH-1:0]    LoadDataW,
    output logic [DATA_WIDTH-1:0]    ResultW,
    output logic [COUNT_WIDTH-1:0]   RetireCount
);

    generate
        if ((DEPTH < 1) || (DEPTH > 4) || (DATA_WIDTH != 32)) begin : g_bad_param
            $error("pipe_reg_mw: DEPTH must be 1..4 and DATA_WIDTH must be 32");
        end
    endgenerate

    typedef struct packed {
        logic                     valid;
        logic                     reg_write;
        logic [1:0]               result_src;
        logic [DATA_WIDTH-1:0]    alu_result;
        logic [DATA_WIDTH-1:0]    read_data;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    pc_plus4;
        logic [FUNCT3_WIDTH-1:0]  funct3;
    } stage_t;

    stage_t                  m_slot;
    stage_t [DEPTH-1:0]      stages;
    stage_t                  w_slot;
    logic [COUNT_WIDTH-1:0]  retire_count;

    assign m_slot = '{valid:      ValidM,
                      reg_write:  RegWriteM,
                      result_src: ResultSrcM,
                      alu_result: ALUResultM,
                      read_data:  RD,
                      rd:         RdM,
                      pc_plus4:   PCPlus4M,
                      funct3:     funct3M};

    // Data fields only move when not stalled; the flush loop below overrides the valid bits last.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stages <= '0;
        end else begin
            if (!StallW) begin
                stages[0] <= m_slot;
                for (int k = 1; k < DEPTH; k++) begin
                    stages[k] <= stages[k-1];
                end
            end
            if (FlushW) begin
                for (int k = 0; k < DEPTH; k++) begin
                    stages[k].valid <= 1'b0;
                end
            end
        end
    end

    assign w_slot = stages[DEPTH-1];

    // The W instruction commits on any unstalled edge, even one that also flushes.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            retire_count <= '0;
        end else if (w_slot.valid && !StallW) begin
            retire_count <= retire_count + COUNT_WIDTH'(1);
        end
    end

    assign ValidW      = w_slot.valid;
    assign RegWriteW   = w_slot.reg_write & w_slot.valid;
    assign ResultSrcW  = w_slot.result_src;
    assign ALUResultW  = w_slot.alu_result;
    assign RdW         = w_slot.rd;
    assign PCPlus4W    = w_slot.pc_plus4;
    assign funct3W     = w_slot.funct3;
    assign ReadDataW   = w_slot.read_data;
    assign RetireCount = retire_count;

    logic [1:0]  byte_off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Misaligned halfwords simply use the upper offset bit; no trap is raised here.
    assign byte_off = w_slot.alu_result[1:0];
    assign ld_byte  = w_slot.read_data[{byte_off, 3'b000} +: 8];
    assign ld_half  = w_slot.read_data[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        LoadDataW = w_slot.read_data;
        case (w_slot.funct3)
            FUNCT3_WIDTH'(3'b000): LoadDataW = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            FUNCT3_WIDTH'(3'b001): LoadDataW = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            FUNCT3_WIDTH'(3'b100): LoadDataW = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            FUNCT3_WIDTH'(3'b101): LoadDataW = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default:               LoadDataW = w_slot.read_data;
        endcase
    end

    always_comb begin
        ResultW = '0;
        case (w_slot.result_src)
            2'b00:   ResultW = w_slot.alu_result;
            2'b01:   ResultW = LoadDataW;
            2'b10:   ResultW = w_slot.pc_plus4;
            default: ResultW = '0;
        endcase
    end

endmodule
